// File: rtl/video_pkg.sv
// Shared video definitions: text fetch states, text geometry
// and the 640x480 timing constants used by the pixel side.
package video_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } text_fetch_state_e;

  localparam int TEXT_COLS = 80;
  localparam int TEXT_ROWS = 30;
  localparam int TEXT_WORDS_PER_FRAME =
    TEXT_COLS * TEXT_ROWS / 2;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = 800;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = 525;

endpackage

// File: rtl/text_mode_fetch_scheduler_if.sv
// Memory read port of the text fetch scheduler:
// request/grant address phase, rvalid data phase.
interface text_mode_fetch_scheduler_if #(
  parameter int ADDR_W = 32
) ();

  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [31:0]       mem_rdata_i;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_gnt_i,
    input  mem_rvalid_i,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_gnt_i,
    output mem_rvalid_i,
    output mem_rdata_i
  );

endinterface

// File: rtl/text_fetch_credit_counter.sv
// Tracks granted reads awaiting rvalid and decides whether
// one more read fits under the cap and the fifo credit.
module text_fetch_credit_counter #(
  parameter int FIFO_DEPTH      = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic grant_i,
  input  logic rvalid_i,
  input  logic [$clog2(FIFO_DEPTH):0] fifo_level_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]
               outstanding_o,
  output logic issue_ok_o
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic [OW-1:0] cnt_q;
  logic          dec;

  // a stray rvalid with nothing in flight must not wrap
  assign dec = rvalid_i && (cnt_q != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      case ({grant_i, dec})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign outstanding_o = cnt_q;

  assign issue_ok_o =
    (32'(cnt_q) < 32'(MAX_OUTSTANDING)) &&
    ((32'(fifo_level_i) + 32'(cnt_q)) <
     32'(FIFO_DEPTH));

endmodule

// File: rtl/text_mode_fetch_scheduler.sv
// Streams one frame of packed text cells from memory into
// the video fifo, paced by fifo credit and a request cap.
module text_mode_fetch_scheduler
  import video_pkg::*;
#(
  parameter int COLS            = TEXT_COLS,
  parameter int ROWS            = TEXT_ROWS,
  parameter int FIFO_DEPTH      = 64,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_W          = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              frame_pulse_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  text_mode_fetch_scheduler_if.master mem,
  input  logic [$clog2(FIFO_DEPTH):0] fifo_level_i,
  output logic              fifo_we_o,
  output logic [31:0]       fifo_wdata_o,
  output logic              fifo_flush_o,
  output logic              busy_o,
  output logic              underrun_o
);

  localparam int WORDS = COLS * ROWS / 2;
  localparam int CW    = $clog2(WORDS + 1);
  localparam int OW    = $clog2(MAX_OUTSTANDING + 1);

  text_fetch_state_e state_q;
  logic [ADDR_W-1:0] base_q;
  logic [CW-1:0]     issue_q;
  logic [CW-1:0]     resp_q;
  logic              pend_q;
  logic              flush_q;
  logic              unr_q;

  logic          fetch;
  logic          req;
  logic          grant;
  logic          last;
  logic          start;
  logic          issue_ok;
  logic [OW-1:0] outst;

  text_fetch_credit_counter #(
    .FIFO_DEPTH      (FIFO_DEPTH),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_credit (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .grant_i       (grant),
    .rvalid_i      (mem.mem_rvalid_i),
    .fifo_level_i  (fifo_level_i),
    .outstanding_o (outst),
    .issue_ok_o    (issue_ok)
  );

  assign fetch = (state_q == FETCH);
  assign start = enable_i && frame_pulse_i;

  // a raised request is held until granted
  assign req = fetch &&
    (pend_q || ((issue_q < CW'(WORDS)) && issue_ok));
  assign grant = req && mem.mem_gnt_i;

  assign fifo_we_o    = fetch && mem.mem_rvalid_i;
  assign fifo_wdata_o = mem.mem_rdata_i;
  assign last = fifo_we_o && (resp_q == CW'(WORDS - 1));

  assign mem.mem_req_o  = req;
  assign mem.mem_addr_o =
    base_q + ADDR_W'({issue_q, 2'b00});

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      base_q  <= '0;
      issue_q <= '0;
      resp_q  <= '0;
      pend_q  <= 1'b0;
      flush_q <= 1'b0;
      unr_q   <= 1'b0;
    end else begin
      flush_q <= 1'b0;
      pend_q  <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            base_q  <= base_addr_i;
            issue_q <= '0;
            resp_q  <= '0;
            state_q <= FETCH;
          end else if (state_q == DONE && !enable_i) begin
            state_q <= IDLE;
          end
        end
        FETCH: begin
          if (grant) issue_q <= issue_q + 1'b1;
          if (fifo_we_o) resp_q <= resp_q + 1'b1;
          // completion wins over a coincident frame pulse
          if (last) begin
            state_q <= DONE;
          end else if (frame_pulse_i) begin
            unr_q   <= 1'b1;
            state_q <= DRAIN;
          end else if (!enable_i) begin
            state_q <= DRAIN;
          end else begin
            pend_q <= req && !grant;
          end
        end
        DRAIN: begin
          if (outst == '0) begin
            flush_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_flush_o = flush_q;
  assign busy_o       = (state_q == FETCH) ||
                        (state_q == DRAIN);
  assign underrun_o   = unr_q;

endmodule

// File: tb/tb_text_mode_fetch_scheduler.sv
// Scoreboard bench: slave model pushes expected cells at grant,
// monitor pops and compares on every fifo write.
module tb_text_mode_fetch_scheduler;

  localparam int WORDS = 1200;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic        frame_pulse_i;
  logic [31:0] base_addr_i;
  logic [6:0]  fifo_level_i;
  logic        fifo_we_o;
  logic [31:0] fifo_wdata_o;
  logic        fifo_flush_o;
  logic        busy_o;
  logic        underrun_o;

  text_mode_fetch_scheduler_if bus ();

  text_mode_fetch_scheduler dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .enable_i      (enable_i),
    .frame_pulse_i (frame_pulse_i),
    .base_addr_i   (base_addr_i),
    .mem           (bus),
    .fifo_level_i  (fifo_level_i),
    .fifo_we_o     (fifo_we_o),
    .fifo_wdata_o  (fifo_wdata_o),
    .fifo_flush_o  (fifo_flush_o),
    .busy_o        (busy_o),
    .underrun_o    (underrun_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] d;
    int          rdy;
  } rsp_t;

  int checks   = 0;
  int failures = 0;

  logic [31:0] sbq[$];
  rsp_t        pipe[$];

  int cyc = 0;
  int lat = 1;
  int idx = 0;
  int req_cycles = 0;
  int wr_cnt = 0;
  int flush_cnt = 0;
  int max_out = 0;
  int stall_at = -1;
  int stall_len = 0;
  int stall_cnt = 0;
  logic [31:0] base_cur = '0;
  logic [31:0] first_addr = '0;
  logic [31:0] last_addr = '0;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3C3, a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // memory slave: grants, records expectations, returns data
  initial begin
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    forever begin
      @(posedge clk_i);
      #1;
      cyc++;
      bus.mem_rvalid_i = 1'b0;
      if (pipe.size() > 0 && pipe[0].rdy <= cyc) begin
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = pipe[0].d;
        void'(pipe.pop_front());
      end
      bus.mem_gnt_i = 1'b0;
      if (bus.mem_req_o) req_cycles++;
      if (idx == stall_at && stall_cnt < stall_len &&
          (stall_cnt > 0 || bus.mem_req_o)) begin
        chk("stall_req", {31'd0, bus.mem_req_o}, 32'd1);
        chk("stall_addr", bus.mem_addr_o, base_cur + 32'd20);
        stall_cnt++;
      end else if (bus.mem_req_o) begin
        bus.mem_gnt_i = 1'b1;
        chk("gnt_addr", bus.mem_addr_o,
            base_cur + 32'(idx) * 4);
        if (idx == 0) first_addr = bus.mem_addr_o;
        last_addr = bus.mem_addr_o;
        sbq.push_back(mdata(base_cur + 32'(idx) * 4));
        pipe.push_back('{mdata(bus.mem_addr_o), cyc + lat});
        idx++;
        chk("outstanding_cap", {31'd0, pipe.size() <= 4},
            32'd1);
      end
      if (pipe.size() > max_out) max_out = pipe.size();
    end
  end

  // monitor: every fifo write must match the oldest expectation
  initial begin
    forever begin
      @(negedge clk_i);
      if (fifo_flush_o) flush_cnt++;
      if (fifo_we_o) begin
        wr_cnt++;
        chk("write_when_full", {31'd0, fifo_level_i < 7'd64},
            32'd1);
        if (sbq.size() == 0) begin
          chk("sb_unexpected_write", fifo_wdata_o, 32'hxxxx_xxxx);
        end else begin
          chk("fifo_wdata", fifo_wdata_o, sbq.pop_front());
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic start_frame(input logic [31:0] b);
    base_addr_i   = b;
    base_cur      = b;
    idx           = 0;
    wr_cnt        = 0;
    frame_pulse_i = 1'b1;
    step();
    frame_pulse_i = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int maxc);
    int n = 0;
    while (busy_o && n < maxc) begin
      step();
      n++;
    end
    chk(nm, {31'd0, busy_o}, 32'd0);
  endtask

  task automatic wait_wr(input string nm, input int w);
    int n = 0;
    while (wr_cnt < w && n < 5000) begin
      step();
      n++;
    end
    chk(nm, {31'd0, wr_cnt >= w}, 32'd1);
  endtask

  int g0, f0, r0, w0;

  initial begin
    rst_i         = 1'b1;
    enable_i      = 1'b0;
    frame_pulse_i = 1'b0;
    base_addr_i   = '0;
    fifo_level_i  = '0;
    repeat (3) step();
    chk("rst_req", {31'd0, bus.mem_req_o}, 32'd0);
    chk("rst_addr", bus.mem_addr_o, 32'd0);
    chk("rst_we", {31'd0, fifo_we_o}, 32'd0);
    chk("rst_flush", {31'd0, fifo_flush_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_underrun", {31'd0, underrun_o}, 32'd0);
    rst_i    = 1'b0;
    enable_i = 1'b1;
    step();

    start_frame(32'h1000);
    chk("nom_busy", {31'd0, busy_o}, 32'd1);
    wait_idle("nom_done", 5000);
    step();
    chk("nom_writes", wr_cnt, WORDS);
    chk("nom_first", first_addr, 32'h1000);
    chk("nom_last", last_addr, 32'h22BC);
    chk("nom_underrun", {31'd0, underrun_o}, 32'd0);
    chk("nom_sb_empty", sbq.size(), 0);

    fifo_level_i = 7'd64;
    start_frame(32'h8000);
    repeat (30) step();
    chk("bp_full_grants", idx, 0);
    chk("bp_full_writes", wr_cnt, 0);
    fifo_level_i = 7'd62;
    lat     = 20;
    max_out = 0;
    repeat (100) step();
    chk("bp_max_out", max_out, 2);
    chk("bp_progress", {31'd0, wr_cnt > 0}, 32'd1);
    fifo_level_i = 7'd0;
    lat = 1;
    wait_idle("bp_done", 5000);
    step();
    chk("bp_writes", wr_cnt, WORDS);
    chk("bp_sb_empty", sbq.size(), 0);

    stall_at  = 5;
    stall_len = 10;
    stall_cnt = 0;
    start_frame(32'h4000);
    wait_idle("stall_done", 5000);
    step();
    chk("stall_cycles", stall_cnt, 10);
    chk("stall_writes", wr_cnt, WORDS);
    chk("stall_last", last_addr, 32'h4000 + 32'h12BC);
    stall_at = -1;

    lat = 3;
    f0  = flush_cnt;
    start_frame(32'h1000);
    wait_wr("ur_reach", 600);
    frame_pulse_i = 1'b1;
    step();
    frame_pulse_i = 1'b0;
    g0 = idx;
    chk("ur_flag", {31'd0, underrun_o}, 32'd1);
    chk("ur_drain_busy", {31'd0, busy_o}, 32'd1);
    wait_idle("ur_drain_end", 100);
    repeat (2) step();
    chk("ur_flush", flush_cnt - f0, 1);
    chk("ur_no_new_req", idx, g0);
    chk("ur_dropped", sbq.size(), 3);
    sbq.delete();
    start_frame(32'h1000);
    wait_idle("ur_refetch", 6000);
    step();
    chk("ur_refetch_first", first_addr, 32'h1000);
    chk("ur_refetch_writes", wr_cnt, WORDS);
    chk("ur_sticky", {31'd0, underrun_o}, 32'd1);

    lat = 1;
    f0  = flush_cnt;
    start_frame(32'h1000);
    wait_wr("dis_reach", 100);
    enable_i = 1'b0;
    wait_idle("dis_drain_end", 100);
    repeat (2) step();
    chk("dis_flush", flush_cnt - f0, 1);
    chk("dis_dropped", sbq.size(), 1);
    sbq.delete();
    r0 = req_cycles;
    frame_pulse_i = 1'b1;
    step();
    frame_pulse_i = 1'b0;
    repeat (20) step();
    chk("dis_no_req", req_cycles, r0);
    chk("dis_idle", {31'd0, busy_o}, 32'd0);

    enable_i = 1'b1;
    start_frame(32'h1000);
    wait_wr("rst_reach", 50);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    w0 = wr_cnt;
    chk("mid_rst_req", {31'd0, bus.mem_req_o}, 32'd0);
    chk("mid_rst_addr", bus.mem_addr_o, 32'd0);
    chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("mid_rst_flush", {31'd0, fifo_flush_o}, 32'd0);
    chk("mid_rst_underrun", {31'd0, underrun_o}, 32'd0);
    repeat (5) step();
    chk("mid_rst_late_write", wr_cnt, w0);
    chk("mid_rst_pipe_empty", pipe.size(), 0);
    sbq.delete();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
